// File: rtl/am_cmd_sched_pkg.sv
// Shared types for the axis-motor command scheduler.
package am_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RUN,
    RUNNING,
    STOPPING,
    DONE,
    ERR
  } state_t;

  // Index width that stays at least one bit wide for tiny N.
  function automatic int clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/am_cmd_sched_if.sv
// Requester-side command bus: packed per-requester fields, one-hot grant, completion pulses.
interface am_cmd_sched_if #(
  parameter int C_REQ_NUM           = 4,
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_SPEED_DATA_WIDTH  = 32
);
  logic [C_REQ_NUM-1:0]                      req_valid;
  logic [C_REQ_NUM-1:0]                      req_ready;
  logic [C_REQ_NUM-1:0]                      req_abs;
  logic [C_REQ_NUM*C_SPEED_DATA_WIDTH-1:0]   req_speed;
  logic [C_REQ_NUM*C_STEP_NUMBER_WIDTH-1:0]  req_step;
  logic [C_REQ_NUM-1:0]                      req_done;
  logic [C_REQ_NUM-1:0]                      req_err;

  modport master (
    output req_valid, req_abs, req_speed, req_step,
    input  req_ready, req_done, req_err
  );

  modport slave (
    input  req_valid, req_abs, req_speed, req_step,
    output req_ready, req_done, req_err
  );
endinterface

// File: rtl/am_cmd_sched_rr_arbiter.sv
// Round-robin search: first requester at or above ptr, wrapping, wins.
module rr_arbiter
  import am_sched_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                       = 1'b1;
        gnt[(int'(ptr) + k) % N]  = 1'b1;
        idx                       = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/am_cmd_sched.sv
// Arbitrates requesters onto one motor port and sequences start / run / stop per command.
module am_cmd_sched
  import am_sched_pkg::*;
#(
  parameter  int C_REQ_NUM           = 4,
  parameter  int C_STEP_NUMBER_WIDTH = 32,
  parameter  int C_SPEED_DATA_WIDTH  = 32,
  parameter  int C_TIMEOUT_WIDTH     = 20,
  localparam int OW                  = clog2(C_REQ_NUM)
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  am_cmd_sched_if.slave                         cmd,
  input  logic                                  abort,
  input  logic [C_TIMEOUT_WIDTH-1:0]            tmo_limit,
  output logic                                  m_sel,
  input  logic                                  m_state,
  output logic                                  m_start,
  output logic                                  m_stop,
  output logic [C_SPEED_DATA_WIDTH-1:0]         m_speed,
  output logic signed [C_STEP_NUMBER_WIDTH-1:0] m_step,
  output logic                                  m_abs,
  output logic                                  busy,
  output logic [OW-1:0]                         owner
);

  state_t                         state, nxt;
  logic [OW-1:0]                  ptr, gidx;
  logic [C_REQ_NUM-1:0]           arb_req, gnt;
  logic                           any;
  logic [C_TIMEOUT_WIDTH-1:0]     wd, wd_inc;
  logic                           timeout;
  logic                           stop_q;
  logic [C_SPEED_DATA_WIDTH-1:0]  sel_speed;
  logic [C_STEP_NUMBER_WIDTH-1:0] sel_step;
  logic                           sel_abs;
  logic                           sel_move;

  // Grants only in IDLE, never while abort is held or reset is asserted.
  assign arb_req = (state == IDLE && resetn && !abort) ? cmd.req_valid : '0;

  rr_arbiter #(.N(C_REQ_NUM)) u_arb (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign cmd.req_ready = gnt;
  assign m_sel         = resetn;

  assign sel_speed = cmd.req_speed[gidx*C_SPEED_DATA_WIDTH +: C_SPEED_DATA_WIDTH];
  assign sel_step  = cmd.req_step[gidx*C_STEP_NUMBER_WIDTH +: C_STEP_NUMBER_WIDTH];
  assign sel_abs   = cmd.req_abs[gidx];
  assign sel_move  = sel_abs || (sel_step != '0);

  // Saturating watchdog; a zero limit disables it.
  assign wd_inc  = (&wd) ? wd : wd + 1'b1;
  assign timeout = (tmo_limit != '0) && (wd_inc >= tmo_limit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (any) nxt = sel_move ? ISSUE : DONE;
      ISSUE:    nxt = WAIT_RUN;
      WAIT_RUN: begin
        if (abort)        nxt = STOPPING;
        else if (m_state) nxt = RUNNING;
        else if (timeout) nxt = ERR;
      end
      RUNNING: begin
        if (abort)         nxt = STOPPING;
        else if (!m_state) nxt = DONE;
      end
      STOPPING: if (!m_state) nxt = ERR;
      DONE:     nxt = IDLE;
      ERR:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    m_start      = (state == ISSUE);
    m_stop       = stop_q;
    busy         = (state != IDLE);
    cmd.req_done = '0;
    cmd.req_err  = '0;
    if (state == DONE) cmd.req_done[owner] = 1'b1;
    if (state == ERR)  cmd.req_err[owner]  = 1'b1;
  end

  // STOPPING is entered once per command, so the stop pulse cannot repeat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stop_q  <= 1'b0;
      wd      <= '0;
      ptr     <= '0;
      owner   <= '0;
      m_speed <= '0;
      m_step  <= '0;
      m_abs   <= 1'b0;
    end else begin
      stop_q <= (nxt == STOPPING) && (state != STOPPING);
      if (state == ISSUE)         wd <= '0;
      else if (state == WAIT_RUN) wd <= wd_inc;
      if (any) begin
        owner   <= gidx;
        ptr     <= (int'(gidx) == C_REQ_NUM - 1) ? '0 : gidx + 1'b1;
        m_speed <= sel_speed;
        m_step  <= sel_step;
        m_abs   <= sel_abs;
      end
    end
  end

endmodule

// File: tb/tb_am_cmd_sched.sv
// Directed bench for am_cmd_sched: arbitration order, sequencing, watchdog, abort, reset.
module tb_am_cmd_sched;
  import am_sched_pkg::*;

  localparam int N   = 4;
  localparam int SPD = 32;
  localparam int STP = 32;
  localparam int TMO = 20;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  abort;
  logic [TMO-1:0]        tmo_limit;
  logic                  m_sel, m_state, m_start, m_stop, m_abs, busy;
  logic [SPD-1:0]        m_speed;
  logic signed [STP-1:0] m_step;
  logic [1:0]            owner;

  int n_chk = 0;
  int n_err = 0;
  int cnt_start = 0, cnt_stop = 0, cnt_done = 0, cnt_errp = 0;
  int s0, s1, s2, s3;

  am_cmd_sched_if #(.C_REQ_NUM(N), .C_STEP_NUMBER_WIDTH(STP), .C_SPEED_DATA_WIDTH(SPD)) cmd ();

  am_cmd_sched #(
    .C_REQ_NUM(N), .C_STEP_NUMBER_WIDTH(STP), .C_SPEED_DATA_WIDTH(SPD), .C_TIMEOUT_WIDTH(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .cmd(cmd), .abort(abort), .tmo_limit(tmo_limit),
    .m_sel(m_sel), .m_state(m_state), .m_start(m_start), .m_stop(m_stop),
    .m_speed(m_speed), .m_step(m_step), .m_abs(m_abs), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_start)        cnt_start++;
    if (m_stop)         cnt_stop++;
    if (|cmd.req_done)  cnt_done++;
    if (|cmd.req_err)   cnt_errp++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [SPD-1:0] spd, input logic [STP-1:0] stp,
                         input logic ab);
    cmd.req_speed[i*SPD +: SPD] = spd;
    cmd.req_step[i*STP +: STP]  = stp;
    cmd.req_abs[i]              = ab;
  endtask

  task automatic do_reset;
    resetn        = 1'b0;
    cmd.req_valid = '0;
    cmd.req_abs   = '0;
    cmd.req_speed = '0;
    cmd.req_step  = '0;
    abort         = 1'b0;
    m_state       = 1'b0;
    tmo_limit     = '0;
    tick;
    tick;
    resetn = 1'b1;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with requests pending to show grants are held off
    do_reset;
    resetn = 1'b0;
    cmd.req_valid = 4'b1111;
    tick;
    chk("rst_ready", cmd.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", m_sel, 0);
    chk("rst_start", m_start, 0);
    chk("rst_owner", owner, 0);

    // T1: single move, 50-cycle run
    do_reset;
    set_req(0, 5, 100, 0);
    cmd.req_valid = 4'b0001;
    s0 = cnt_start;
    #1 chk("t1_ready", cmd.req_ready, 4'b0001);
    tick;
    chk("t1_start", m_start, 1);
    chk("t1_speed", m_speed, 5);
    chk("t1_step", m_step, 100);
    chk("t1_busy", busy, 1);
    chk("t1_sel", m_sel, 1);
    cmd.req_valid = '0;
    tick;
    chk("t1_start_off", m_start, 0);
    m_state = 1'b1;
    tick;
    repeat (49) tick;
    chk("t1_no_early_done", cmd.req_done, 0);
    m_state = 1'b0;
    tick;
    chk("t1_done", cmd.req_done, 4'b0001);
    tick;
    chk("t1_done_off", cmd.req_done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_nstart", cnt_start - s0, 1);

    // T2: all requesters held, rotating grants
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + i, 10 + i, 0);
    cmd.req_valid = 4'b1111;
    s0 = cnt_start;
    for (int g = 0; g < 5; g++) begin
      #1 chk("t2_ready", cmd.req_ready, 4'b0001 << (g % N));
      tick;
      chk("t2_start", m_start, 1);
      chk("t2_owner", owner, g % N);
      chk("t2_step", m_step, 10 + (g % N));
      m_state = 1'b1;
      tick;
      tick;
      m_state = 1'b0;
      tick;
      chk("t2_done", cmd.req_done, 4'b0001 << (g % N));
      tick;
    end
    cmd.req_valid = '0;
    chk("t2_nstart", cnt_start - s0, 5);

    // T3: watchdog timeout with the motor never starting
    do_reset;
    tmo_limit = 16;
    set_req(2, 7, -5, 0);
    cmd.req_valid = 4'b0100;
    s1 = cnt_stop;
    #1 chk("t3_ready", cmd.req_ready, 4'b0100);
    tick;
    chk("t3_start", m_start, 1);
    cmd.req_valid = '0;
    repeat (15) tick;
    tick;
    chk("t3_no_early_err", cmd.req_err, 0);
    tick;
    chk("t3_err", cmd.req_err, 4'b0100);
    chk("t3_owner", owner, 2);
    tick;
    chk("t3_idle", busy, 0);
    chk("t3_nstop", cnt_stop - s1, 0);

    // T4: abort while running, watchdog disabled during a long start wait
    do_reset;
    set_req(1, 9, 200, 1);
    cmd.req_valid = 4'b0010;
    s1 = cnt_stop;
    s2 = cnt_done;
    s3 = cnt_errp;
    #1 chk("t4_ready", cmd.req_ready, 4'b0010);
    tick;
    chk("t4_start", m_start, 1);
    chk("t4_abs", m_abs, 1);
    cmd.req_valid = '0;
    repeat (30) tick;
    chk("t4_wd_off_busy", busy, 1);
    chk("t4_wd_off_err", cnt_errp - s3, 0);
    m_state = 1'b1;
    tick;
    tick;
    abort = 1'b1;
    tick;
    chk("t4_stop", m_stop, 1);
    tick;
    chk("t4_stop_once", m_stop, 0);
    repeat (3) tick;
    abort = 1'b0;
    tick;
    m_state = 1'b0;
    tick;
    chk("t4_err", cmd.req_err, 4'b0010);
    chk("t4_no_done", cmd.req_done, 0);
    tick;
    chk("t4_nstop", cnt_stop - s1, 1);
    chk("t4_ndone", cnt_done - s2, 0);

    // Abort in IDLE blocks grants; abort beats a simultaneous run-fall
    do_reset;
    set_req(0, 1, 1, 0);
    abort = 1'b1;
    cmd.req_valid = 4'b0001;
    #1 chk("ab_idle_ready", cmd.req_ready, 0);
    tick;
    chk("ab_idle_busy", busy, 0);
    abort = 1'b0;
    #1 chk("ab_release_ready", cmd.req_ready, 4'b0001);
    tick;
    cmd.req_valid = '0;
    m_state = 1'b1;
    tick;
    tick;
    abort   = 1'b1;
    m_state = 1'b0;
    tick;
    chk("ab_win_stop", m_stop, 1);
    chk("ab_win_no_done", cmd.req_done, 0);
    abort = 1'b0;
    tick;
    chk("ab_win_err", cmd.req_err, 4'b0001);
    tick;

    // T5: null move completes without touching the motor
    do_reset;
    set_req(3, 4, 0, 0);
    cmd.req_valid = 4'b1000;
    s0 = cnt_start;
    #1 chk("t5_ready", cmd.req_ready, 4'b1000);
    tick;
    chk("t5_done", cmd.req_done, 4'b1000);
    chk("t5_start", m_start, 0);
    cmd.req_valid = '0;
    tick;
    chk("t5_idle", busy, 0);
    chk("t5_done_off", cmd.req_done, 0);
    chk("t5_nstart", cnt_start - s0, 0);

    // T6: async reset mid-run
    do_reset;
    set_req(2, 11, 33, 0);
    cmd.req_valid = 4'b0100;
    #1;
    tick;
    cmd.req_valid = '0;
    m_state = 1'b1;
    tick;
    tick;
    chk("t6_running", busy, 1);
    chk("t6_owner_pre", owner, 2);
    s2 = cnt_done;
    s3 = cnt_errp;
    #2 resetn = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_sel", m_sel, 0);
    chk("t6_step", m_step, 0);
    chk("t6_speed", m_speed, 0);
    chk("t6_owner", owner, 0);
    chk("t6_start", m_start, 0);
    chk("t6_stop", m_stop, 0);
    tick;
    m_state = 1'b0;
    resetn  = 1'b1;
    tick;
    tick;
    chk("t6_no_done", cnt_done - s2, 0);
    chk("t6_no_err", cnt_errp - s3, 0);
    cmd.req_valid = 4'b1111;
    #1 chk("t6_ptr0", cmd.req_ready, 4'b0001);
    cmd.req_valid = '0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
